// File: rtl/ram_bist_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : ram_bist_sequencer
// Desc   : LFSR write/read-back self-test for a 64-word single-port RAM
//          wrapper. All state is clocked on the falling edge of clk.
//          Option macro RAM_BIST_INVERT_PASS_EN adds an inverted-payload pass.
// Rev    : 1.0
// ============================================================================
module ram_bist_sequencer #(
    parameter int          WIDTH = 32,
    parameter logic [24:0] SEED  = 25'h1ACE5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] cmd_out,
    input  logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [6:0]       err_count,
    output logic [5:0]       first_err_addr
);
    localparam logic [24:0] c_SEED = (SEED == 25'd0) ? 25'd1 : SEED;
    localparam int          c_PW   = WIDTH - 7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_WINV  = 3'd3,
        S_RINV  = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    function automatic logic [24:0] f_lfsr_step(input logic [24:0] s);
        return {s[23:0], s[24] ^ s[21]};
    endfunction

    function automatic logic [WIDTH-1:0] f_cmd(input logic [24:0] s, input logic [5:0] a,
                                               input logic we, input logic inv);
        logic [c_PW-1:0] pl;
        pl = c_PW'(s);
        return {(inv ? ~pl : pl), a, we};
    endfunction

    state_t                 r_state;
    logic [WIDTH-1:0]       r_cmd;
    logic [24:0]            r_lfsr;
    logic [5:0]             r_addr;
    logic                   r_drain;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pass;
    logic [6:0]             r_err;
    logic [5:0]             r_first;
    logic [2:0]             r_vld;
    logic [2:0][WIDTH-1:0]  r_exp;
    logic [2:0][5:0]        r_pa;

    state_t      w_next_state;
    logic        w_issue;
    logic        w_we;
    logic        w_inv;
    logic        w_wrap;
    logic [24:0] w_src_lfsr;
    logic [5:0]  w_src_addr;
    logic        w_start;
    logic        w_mismatch;
    logic [6:0]  w_err_next;

    // r_addr == 0 means the previous phase just issued address 63 (or none yet),
    // so the next command restarts the address/LFSR sequence.
    assign w_wrap     = (r_addr == 6'd0);
    assign w_src_lfsr = w_wrap ? c_SEED : r_lfsr;
    assign w_src_addr = w_wrap ? 6'd0 : r_addr;
    assign w_start    = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
    assign w_mismatch = r_vld[2] && (rd_data != r_exp[2]);

    always_comb begin
        w_err_next = r_err;
        if (w_mismatch && (r_err != 7'd127)) begin
            w_err_next = r_err + 7'd1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_we         = 1'b0;
        w_inv        = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next_state = S_WRITE;
                    w_issue      = 1'b1;
                    w_we         = 1'b1;
                end
            end
            S_WRITE: begin
                w_issue = 1'b1;
                w_we    = !w_wrap;
                if (w_wrap) w_next_state = S_READ;
            end
            S_READ: begin
                if (w_wrap) begin
`ifdef RAM_BIST_INVERT_PASS_EN
                    w_next_state = S_WINV;
                    w_issue      = 1'b1;
                    w_we         = 1'b1;
                    w_inv        = 1'b1;
`else
                    w_next_state = S_DRAIN;
`endif
                end else begin
                    w_issue = 1'b1;
                end
            end
            S_WINV: begin
                w_issue = 1'b1;
                w_inv   = 1'b1;
                w_we    = !w_wrap;
                if (w_wrap) w_next_state = S_RINV;
            end
            S_RINV: begin
                if (w_wrap) begin
                    w_next_state = S_DRAIN;
                end else begin
                    w_issue = 1'b1;
                    w_inv   = 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_drain) w_next_state = S_DONE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cmd   <= '0;
            r_lfsr  <= '0;
            r_addr  <= '0;
            r_drain <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_first <= '0;
            r_vld   <= '0;
            r_exp   <= '0;
            r_pa    <= '0;
        end else begin
            r_state <= w_next_state;
            r_cmd   <= w_issue ? f_cmd(w_src_lfsr, w_src_addr, w_we, w_inv) : '0;
            if (w_issue) begin
                r_lfsr <= f_lfsr_step(w_src_lfsr);
                r_addr <= w_src_addr + 6'd1;
            end
            r_drain <= (r_state == S_DRAIN) && !r_drain;
            r_busy  <= (w_next_state != S_IDLE) && (w_next_state != S_DONE);
            r_done  <= (w_next_state == S_DONE);
            r_pass  <= (w_next_state == S_DONE) && (w_err_next == 7'd0);
            // Expected word is the write image: write-enable bit forced to 1.
            r_vld   <= {r_vld[1:0], w_issue && !w_we};
            r_exp   <= {r_exp[1:0], f_cmd(w_src_lfsr, w_src_addr, 1'b1, w_inv)};
            r_pa    <= {r_pa[1:0], w_src_addr};
            if (w_start) begin
                r_err   <= '0;
                r_first <= '0;
            end else if (w_mismatch) begin
                r_err <= w_err_next;
                if (r_err == 7'd0) r_first <= r_pa[2];
            end
        end
    end

    assign cmd_out        = r_cmd;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_err_addr = r_first;

endmodule
`default_nettype wire

// File: tb/tb_ram_bist_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_ram_bist_sequencer
// Desc   : Directed bench for ram_bist_sequencer with a behavioural RAM wrapper.
// Rev    : 1.0
// ============================================================================
module tb_ram_bist_sequencer;
    localparam int W = 32;
`ifdef RAM_BIST_INVERT_PASS_EN
    localparam int         DONE_EDGE = 258;
    localparam logic [6:0] ALL_ERR   = 7'd127;
`else
    localparam int         DONE_EDGE = 130;
    localparam logic [6:0] ALL_ERR   = 7'd64;
`endif

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] mask  = '0;
    logic [W-1:0] cmd0, cmd1, rd0, rd1;
    logic         busy0, done0, pass0, busy1, done1, pass1;
    logic [6:0]   err0, err1;
    logic [5:0]   fea0, fea1;
    logic [W-1:0] mem0 [64];
    logic [W-1:0] mem1 [64];
    logic [W-1:0] q0, q1, dout0, dout1;
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;

    always #5 clk = ~clk;

    ram_bist_sequencer #(.WIDTH(W), .SEED(25'h1ACE5)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .cmd_out(cmd0), .rd_data(rd0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_err_addr(fea0)
    );

    ram_bist_sequencer #(.WIDTH(W), .SEED(25'h0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .cmd_out(cmd1), .rd_data(rd1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_err_addr(fea1)
    );

    // RAM wrapper model: write commits at the edge ending the command cycle,
    // read data passes through the array register and the output register.
    always @(negedge clk) begin
        if (cmd0[0]) mem0[cmd0[6:1]] <= cmd0;
        q0    <= mem0[cmd0[6:1]];
        dout0 <= q0;
        if (cmd1[0]) mem1[cmd1[6:1]] <= cmd1;
        q1    <= mem1[cmd1[6:1]];
        dout1 <= q1;
    end
    assign rd0 = dout0 ^ mask;
    assign rd1 = dout1;

    task automatic step_to(input int k);
        while (cyc < k) begin
            @(posedge clk);
            cyc++;
        end
    endtask

    task automatic pulse_start;
        @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        rst = 1'b0;
        @(posedge clk);
        n_checks++; if (cmd0 !== '0) begin n_fail++; $display("FAIL reset_cmd: got %h want 0", cmd0); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
        n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done0); end
        n_checks++; if (pass0 !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b want 0", pass0); end
        n_checks++; if (err0 !== 7'd0) begin n_fail++; $display("FAIL reset_err: got %0d want 0", err0); end
        n_checks++; if (fea0 !== 6'd0) begin n_fail++; $display("FAIL reset_fea: got %0d want 0", fea0); end
    endtask

    task automatic test_clean_run;
        pulse_start();
        n_checks++; if (cmd0 !== 32'h00D67281) begin n_fail++; $display("FAIL clean_cmd_c0: got %h want 00d67281", cmd0); end
        n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL clean_busy_c0: got %b want 1", busy0); end
        n_checks++; if (cmd1 !== 32'h00000081) begin n_fail++; $display("FAIL seed0_cmd_c0: got %h want 00000081", cmd1); end
        step_to(1);
        n_checks++; if (cmd0 !== 32'h01ACE503) begin n_fail++; $display("FAIL clean_cmd_c1: got %h want 01ace503", cmd0); end
        n_checks++; if (cmd1 !== 32'h00000103) begin n_fail++; $display("FAIL seed0_cmd_c1: got %h want 00000103", cmd1); end
        step_to(64);
        n_checks++; if (cmd0 !== 32'h00D67280) begin n_fail++; $display("FAIL clean_cmd_c64: got %h want 00d67280", cmd0); end
`ifdef RAM_BIST_INVERT_PASS_EN
        step_to(128);
        n_checks++; if (cmd0 !== 32'h0F298D01) begin n_fail++; $display("FAIL clean_cmd_c128: got %h want 0f298d01", cmd0); end
`endif
        step_to(DONE_EDGE - 1);
        n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL clean_done_early: got %b want 0", done0); end
        n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL clean_busy_drain: got %b want 1", busy0); end
        step_to(DONE_EDGE);
        n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL clean_done: got %b want 1", done0); end
        n_checks++; if (pass0 !== 1'b1) begin n_fail++; $display("FAIL clean_pass: got %b want 1", pass0); end
        n_checks++; if (err0 !== 7'd0) begin n_fail++; $display("FAIL clean_err: got %0d want 0", err0); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL clean_busy_done: got %b want 0", busy0); end
        n_checks++; if (pass1 !== 1'b1) begin n_fail++; $display("FAIL seed0_pass: got %b want 1", pass1); end
        n_checks++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL seed0_done: got %b want 1", done1); end
    endtask

    task automatic test_single_error;
        pulse_start();
        step_to(71);
        mask = 32'h8000_0000;
        step_to(72);
        mask = '0;
        step_to(DONE_EDGE);
        n_checks++; if (err0 !== 7'd1) begin n_fail++; $display("FAIL single_err: got %0d want 1", err0); end
        n_checks++; if (fea0 !== 6'd5) begin n_fail++; $display("FAIL single_fea: got %0d want 5", fea0); end
        n_checks++; if (pass0 !== 1'b0) begin n_fail++; $display("FAIL single_pass: got %b want 0", pass0); end
        n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b want 1", done0); end
    endtask

    task automatic test_all_errors;
        mask = '1;
        pulse_start();
        step_to(DONE_EDGE);
        mask = '0;
        n_checks++; if (err0 !== ALL_ERR) begin n_fail++; $display("FAIL all_err: got %0d want %0d", err0, ALL_ERR); end
        n_checks++; if (fea0 !== 6'd0) begin n_fail++; $display("FAIL all_fea: got %0d want 0", fea0); end
        n_checks++; if (pass0 !== 1'b0) begin n_fail++; $display("FAIL all_pass: got %b want 0", pass0); end
    endtask

    task automatic test_restart_from_done;
        pulse_start();
        n_checks++; if (err0 !== 7'd0) begin n_fail++; $display("FAIL restart_err_clear: got %0d want 0", err0); end
        n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL restart_done: got %b want 0", done0); end
        n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b want 1", busy0); end
        step_to(DONE_EDGE);
        n_checks++; if (pass0 !== 1'b1) begin n_fail++; $display("FAIL restart_pass: got %b want 1", pass0); end
    endtask

    task automatic test_mid_reset;
        pulse_start();
        step_to(60);
        mask = '1;
        step_to(70);
        n_checks++; if (err0 !== 7'd4) begin n_fail++; $display("FAIL midrst_err_pre: got %0d want 4", err0); end
        rst = 1'b1;
        step_to(71);
        rst  = 1'b0;
        mask = '0;
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy0); end
        n_checks++; if (cmd0 !== '0) begin n_fail++; $display("FAIL midrst_cmd: got %h want 0", cmd0); end
        n_checks++; if (err0 !== 7'd0) begin n_fail++; $display("FAIL midrst_err: got %0d want 0", err0); end
        n_checks++; if (fea0 !== 6'd0) begin n_fail++; $display("FAIL midrst_fea: got %0d want 0", fea0); end
        step_to(71 + DONE_EDGE);
        n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done: got %b want 0", done0); end
        n_checks++; if (err0 !== 7'd0) begin n_fail++; $display("FAIL midrst_no_cmp: got %0d want 0", err0); end
        pulse_start();
        step_to(DONE_EDGE);
        n_checks++; if (pass0 !== 1'b1) begin n_fail++; $display("FAIL midrst_rerun_pass: got %b want 1", pass0); end
    endtask

    task automatic test_ignored_start;
        pulse_start();
        step_to(30);
        start = 1'b1;
        step_to(31);
        start = 1'b0;
        n_checks++; if (cmd0[6:0] !== 7'h3F) begin n_fail++; $display("FAIL ign_cmd_c31: got %h want 3f", cmd0[6:0]); end
        n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL ign_busy: got %b want 1", busy0); end
        step_to(DONE_EDGE - 1);
        n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL ign_done_early: got %b want 0", done0); end
        step_to(DONE_EDGE);
        n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL ign_done: got %b want 1", done0); end
        n_checks++; if (pass0 !== 1'b1) begin n_fail++; $display("FAIL ign_pass: got %b want 1", pass0); end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_single_error();
        test_all_errors();
        test_restart_from_done();
        test_mid_reset();
        test_ignored_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_bist_sequencer.md
# ram_bist_sequencer

Self-test command sequencer that drives the 32-bit command word of the single-port RAM wrapper (`single_port_ram_top`): `data_in[0]` = write enable, `data_in[6:1]` = address, the full word is the write data. It writes an LFSR pattern to all 64 locations, reads every location back, and compares the wrapper's registered `data_out` against the expected word. It reports pass/fail, an error count and the first failing address. All state is clocked on the falling edge of `clk`, the same edge the RAM and its output register use.

## Interface
- `WIDTH`, 32 — command/data word width; must be ≥ 7; the payload occupies bits `[WIDTH-1:7]`.
- `SEED`, 25'h1ACE5 — LFSR seed; a value of 0 is replaced by 1.
- `clk`  in  1  clock; all registers update on its falling edge.
- `rst`  in  1  synchronous, active-high reset, sampled on the falling edge of `clk`.
- `start`  in  1  begin a test run; sampled only in IDLE or DONE.
- `cmd_out`  out  WIDTH  command word to the RAM wrapper `data_in`.
- `rd_data`  in  WIDTH  RAM wrapper `data_out`.
- `busy`  out  1  high from WRITE through DRAIN.
- `done`  out  1  high in DONE.
- `pass`  out  1  `done && err_count == 0`.
- `err_count`  out  7  mismatch count; saturates at 127.
- `first_err_addr`  out  6  address of the first mismatch; 0 if there is none.

Reset value of every output is 0: `cmd_out` = 0 is a read of address 0 and is harmless.

## Operation
- States: IDLE → WRITE → READ → DRAIN → DONE.
  - IDLE or DONE with `start` = 1 → WRITE.
  - WRITE → READ after address 63.
  - READ → DRAIN after address 63.
  - DRAIN → DONE after 2 cycles.
  - DONE holds its results until `start` or `rst`.
- Entering WRITE clears `err_count` and `first_err_addr`, sets address = 0 and loads the LFSR with `SEED`.
- LFSR: 25 bits, polynomial x^25 + x^22 + 1, Fibonacci form, advanced once per command cycle.
- WRITE cycle: `cmd_out = {lfsr[WIDTH-8:0], addr, 1'b1}`, then address increments (6-bit wrap).
- READ:
  - Address and LFSR are reloaded with 0 and `SEED` at the WRITE→READ transition.
  - `cmd_out = {lfsr-payload, addr, 1'b0}`.
  - The expected word is `{payload, addr, 1'b1}`, i.e. exactly the word written, including the write-enable bit.
- Compare pipeline:
  - The expected word and its address travel through a 2-stage delay line with a valid tag.
  - A read held in `cmd_out` during cycle c is compared against `rd_data` at the falling edge that ends cycle c+2.
  - Only valid-tagged slots are compared.
- On mismatch: `err_count` increments (saturating); `first_err_addr` is captured only when `err_count` was 0.
- `start` while `busy` is ignored.
- `rst` mid-run → IDLE next edge. Outputs, the pipeline valid tags and the counters all return to 0; no further compares occur.

## Timing
- `start` sampled at falling edge 0 → `cmd_out` holds the write of address 0 during cycle 0.
- Cycles 0–63: writes; 64–127: reads; 128–129: DRAIN.
- `done` and `pass` are valid from edge 130 and are registered.
- Read-after-write to the same address needs no extra spacing: the write commits at the edge ending its cycle.
- Combinational inputs: `rd_data` feeds the comparator only; there is no path from `rd_data` to `cmd_out`.

## Configuration
- `RAM_BIST_INVERT_PASS_EN` defined:
  - Adds WRITE_INV and READ_INV after READ (READ → WRITE_INV → READ_INV → DRAIN).
  - Each uses the same address and LFSR sequence with the payload bitwise inverted; bit 0 is still 1 for writes and 0 for reads.
  - Compares from READ continue in the pipeline during WRITE_INV.
  - `done` at edge 258.
- Not defined: single pass, `done` at edge 130.

## Test plan
- Fault-free RAM, `start` pulse at edge 0:
  - `cmd_out` at cycle 0 = `{payload0, 6'd0, 1'b1}`; at cycle 64 = `{payload0, 6'd0, 1'b0}`.
  - `done` = 1, `pass` = 1 and `err_count` = 0 at edge 130 (258 with the macro).
- Force bit 31 of `rd_data` high during the cycle carrying the address-5 read result → `err_count` = 1, `first_err_addr` = 5, `pass` = 0.
- Corrupt every read result → `err_count` = 64 (127, saturated, with the macro), `first_err_addr` = 0.
- Assert `rst` for one edge at cycle 70 → IDLE, `busy` = 0, `cmd_out` = 0, counters 0. No `done` follows; a new `start` completes a full run with `pass` = 1.
- Pulse `start` at cycle 30 → ignored, completion still at edge 130. `start` in DONE → new run, and `err_count` from a prior failed run is cleared at the start edge.
- `SEED` = 0 → LFSR runs from 1, `pass` = 1.
